// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: arbitrates EX branch / ID jump / exception and issues one registered redirect.
// Optional per-source redirect counters under `PC_REDIRECT_STATS_EN.
module pc_redirect_ctrl #(
    parameter logic [31:0] PC_EXC = 32'hbfc00380,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 fetch_ready,
    input  logic                 ex_br_valid,
    input  logic [31:0]          ex_br_target,
    input  logic                 id_jump_valid,
    input  logic [31:0]          id_jump_target,
    input  logic                 ds_fetched,
    input  logic                 exc_valid,
    output logic                 req_accept,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic [1:0]           redirect_src,
    output logic                 flush,
    output logic                 lost_req,
    output logic [3*CNT_W-1:0]   stat_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DS = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_BR   = 2'd1;
    localparam logic [1:0] SRC_JUMP = 2'd2;
    localparam logic [1:0] SRC_EXC  = 2'd3;

    state_t state;

    assign req_accept     = (state == IDLE) && !exc_valid;
    assign redirect_valid = (state == ISSUE) && fetch_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            redirect_pc  <= '0;
            redirect_src <= SRC_NONE;
            flush        <= 1'b0;
            lost_req     <= 1'b0;
        end else begin
            flush <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (exc_valid) begin
                        redirect_pc  <= PC_EXC;
                        redirect_src <= SRC_EXC;
                        flush        <= 1'b1;
                        state        <= ISSUE;
                    end else if (ex_br_valid) begin
                        // Branch in EX is older than the jump in ID, so it wins.
                        redirect_pc  <= ex_br_target;
                        redirect_src <= SRC_BR;
                        if (id_jump_valid) lost_req <= 1'b1;
                        state        <= ds_fetched ? ISSUE : WAIT_DS;
                    end else if (id_jump_valid) begin
                        redirect_pc  <= id_jump_target;
                        redirect_src <= SRC_JUMP;
                        state        <= ds_fetched ? ISSUE : WAIT_DS;
                    end
                end
                WAIT_DS: begin
                    if (ex_br_valid || id_jump_valid) lost_req <= 1'b1;
                    if (exc_valid) begin
                        redirect_pc  <= PC_EXC;
                        redirect_src <= SRC_EXC;
                        flush        <= 1'b1;
                        state        <= ISSUE;
                    end else if (fetch_ready) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ex_br_valid || id_jump_valid) lost_req <= 1'b1;
                    // An exception overrides a pending non-exception redirect; if the old one is
                    // consumed this same cycle, the exception redirect simply follows next cycle.
                    if (exc_valid && redirect_src != SRC_EXC) begin
                        redirect_pc  <= PC_EXC;
                        redirect_src <= SRC_EXC;
                        flush        <= 1'b1;
                    end else if (fetch_ready) begin
                        redirect_src <= SRC_NONE;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PC_REDIRECT_STATS_EN
    logic [CNT_W-1:0] cnt_br;
    logic [CNT_W-1:0] cnt_jump;
    logic [CNT_W-1:0] cnt_exc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_br   <= '0;
            cnt_jump <= '0;
            cnt_exc  <= '0;
        end else if (redirect_valid) begin
            unique case (redirect_src)
                SRC_BR:   cnt_br   <= cnt_br + 1'b1;
                SRC_JUMP: cnt_jump <= cnt_jump + 1'b1;
                SRC_EXC:  cnt_exc  <= cnt_exc + 1'b1;
                default:  ;
            endcase
        end
    end

    assign stat_cnt = {cnt_exc, cnt_jump, cnt_br};
`else
    assign stat_cnt = '0;
`endif

endmodule
